dmem_responder: RTL and testbench

Word-addressed data-memory responder that sits on the processor's data port and services one read or write per request, with programmable wait states and a `ready` handshake. It also decodes a result mailbox address: the first write there latches a sticky `done`/`pass` verdict. A free-running watchdog flags a `timeout`, so self-checking programs finish in hardware rather than relying on bench-side address matching.

---
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with programmable wait states, a sticky result
// mailbox (done/pass) and a free-running watchdog (timeout).
module dmem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT        = 2,
    parameter logic [31:0] MAILBOX_ADR = 32'd84,
    parameter logic [31:0] EXPECT      = 32'hFFFF7F02,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        done,
    output logic        pass,
    output logic        timeout
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e           state_q;
    logic [3:0]       wait_q;
    logic             we_q;
    logic [31:0]      adr_q;
    logic [31:0]      wdata_q;
    logic [WDW-1:0]   wd_q;
    logic [31:0]      mem [DEPTH];

    logic             enter_resp;
    logic             act_we;
    logic [31:0]      act_adr;
    logic [31:0]      act_wdata;
    logic [AW-1:0]    act_idx;
    logic             set_done;
    logic [WDW-1:0]   wd_next;

    // With zero wait states the transaction completes on the accepting edge, so the
    // live request fields are used instead of the latched copies.
    always_comb begin
        enter_resp = 1'b0;
        act_we     = we_q;
        act_adr    = adr_q;
        act_wdata  = wdata_q;
        if (WAIT == 0) begin
            enter_resp = (state_q == StIdle) && req;
            act_we     = we;
            act_adr    = adr;
            act_wdata  = wdata;
        end else begin
            enter_resp = (state_q == StBusy) && (wait_q == 4'd1);
        end
        act_idx  = act_adr[AW+1:2];
        set_done = enter_resp && act_we && (act_adr == MAILBOX_ADR) && !done;
        wd_next  = (wd_q == WDW'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
    end

    // Memory shares the reset-qualified block so an aborted transaction never writes it;
    // the array itself is never cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            wdata_q <= 32'd0;
            wd_q    <= '0;
            rdata   <= 32'd0;
            ready   <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        we_q    <= we;
                        adr_q   <= adr;
                        wdata_q <= wdata;
                        wait_q  <= 4'(WAIT);
                        state_q <= (WAIT == 0) ? StResp : StBusy;
                    end
                end
                StBusy: begin
                    wait_q <= wait_q - 4'd1;
                    if (wait_q == 4'd1) state_q <= StResp;
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            if (enter_resp) begin
                ready <= 1'b1;
                if (act_we) mem[act_idx] <= act_wdata;
                else        rdata        <= mem[act_idx];
            end

            if (set_done) begin
                done <= 1'b1;
                pass <= (act_wdata == EXPECT);
            end

            wd_q <= wd_next;
            if ((wd_next == WDW'(TIMEOUT)) && !done && !set_done) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: instance A (WAIT=2, TIMEOUT=1000) and instance B
// (WAIT=0, TIMEOUT=20) share the request bus; the idle one is held in reset.
module tb_dmem_responder;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, done_a, done_b, pass_a, pass_b, timeout_a, timeout_b;
    logic        sel;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.DEPTH(64), .WAIT(2), .MAILBOX_ADR(32'd84), .EXPECT(32'hFFFF7F02),
                     .TIMEOUT(1000)) u_dut_a (
        .clk(clk), .reset(rst_a), .req(req), .we(we), .adr(adr), .wdata(wdata),
        .rdata(rdata_a), .ready(ready_a), .done(done_a), .pass(pass_a), .timeout(timeout_a)
    );

    dmem_responder #(.DEPTH(64), .WAIT(0), .MAILBOX_ADR(32'd84), .EXPECT(32'hFFFF7F02),
                     .TIMEOUT(20)) u_dut_b (
        .clk(clk), .reset(rst_b), .req(req), .we(we), .adr(adr), .wdata(wdata),
        .rdata(rdata_b), .ready(ready_b), .done(done_b), .pass(pass_b), .timeout(timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the selected DUT back in IDLE.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
        logic rdy;
        req   = 1'b1;
        we    = w;
        adr   = a;
        wdata = d;
        lat   = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            rdy = sel ? ready_b : ready_a;
        end while (!rdy && lat < 40);
        rd  = sel ? rdata_b : rdata_a;
        req = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    int          lat;

    initial begin
        sel   = 1'b1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        adr   = 32'd0;
        wdata = 32'd0;
        repeat (3) @(negedge clk);

        // Instance B: reset state and watchdog
        check("b_reset_rdata", rdata_b, 32'd0);
        check("b_reset_flags", {ready_b, done_b, pass_b, timeout_b}, 4'b0000);
        rst_b = 1'b1;
        repeat (19) @(negedge clk);
        check("b_timeout_cyc19", timeout_b, 1'b0);
        @(negedge clk);
        check("b_timeout_cyc20", {done_b, timeout_b}, 2'b01);

        // Back-to-back zero-wait writes with req held high
        req = 1'b1; we = 1'b1; adr = 32'd4; wdata = 32'h1111_0004;
        @(negedge clk);
        check("b_b2b_ready0", ready_b, 1'b1);
        adr = 32'd12; wdata = 32'h2222_000C;
        @(negedge clk);
        check("b_b2b_ready1", ready_b, 1'b0);
        @(negedge clk);
        check("b_b2b_ready2", ready_b, 1'b1);
        req = 1'b0;
        @(negedge clk);
        check("b_b2b_ready3", ready_b, 1'b0);
        xact(1'b0, 32'd4, 32'd0, rd, lat);
        check("b_rd4_data", rd, 32'h1111_0004);
        check("b_rd4_lat", lat, 1);
        xact(1'b0, 32'd12, 32'd0, rd, lat);
        check("b_rd12_data", rd, 32'h2222_000C);
        check("b_timeout_sticky", timeout_b, 1'b1);

        // Instance A
        rst_b = 1'b0;
        sel   = 1'b0;
        check("a_reset_flags", {ready_a, done_a, pass_a, timeout_a}, 4'b0000);
        rst_a = 1'b1;
        @(negedge clk);
        xact(1'b1, 32'd8, 32'h1234_5678, rd, lat);
        check("a_wr8_lat", lat, 3);
        xact(1'b0, 32'd8, 32'd0, rd, lat);
        check("a_rd8_lat", lat, 3);
        check("a_rd8_data", rd, 32'h1234_5678);
        check("a_flags_idle", {done_a, pass_a, timeout_a}, 3'b000);

        xact(1'b1, 32'h100, 32'hA5A5_A5A5, rd, lat);
        xact(1'b0, 32'd0, 32'd0, rd, lat);
        check("a_alias_rd0", rd, 32'hA5A5_A5A5);

        // Reset while BUSY aborts the write
        req = 1'b1; we = 1'b1; adr = 32'd8; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("a_abort_rdata", rdata_a, 32'd0);
        check("a_abort_flags", {ready_a, done_a, pass_a, timeout_a}, 4'b0000);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        xact(1'b0, 32'd8, 32'd0, rd, lat);
        check("a_abort_word_kept", rd, 32'h1234_5678);

        // Mailbox compare includes adr[1:0]
        xact(1'b1, 32'd85, 32'hFFFF_7F02, rd, lat);
        check("a_mbox_adr85_nodone", done_a, 1'b0);
        xact(1'b0, 32'd84, 32'd0, rd, lat);
        check("a_adr85_word21", rd, 32'hFFFF_7F02);

        xact(1'b1, 32'd84, 32'hFFFF_7F02, rd, lat);
        check("a_mbox_pass", {done_a, pass_a}, 2'b11);
        xact(1'b1, 32'd84, 32'd0, rd, lat);
        check("a_mbox_sticky", {done_a, pass_a}, 2'b11);
        xact(1'b0, 32'd84, 32'd0, rd, lat);
        check("a_mbox_rd", rd, 32'd0);

        // Failing verdict; watchdog stays quiet once done
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        xact(1'b1, 32'd84, 32'd7, rd, lat);
        check("a_mbox_fail", {done_a, pass_a, timeout_a}, 3'b100);
        repeat (1100) @(negedge clk);
        check("a_no_timeout", {done_a, pass_a, timeout_a}, 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
